axi_lite_mem_arbiter: RTL and testbench

Two-master, one-slave AXI4-Lite arbiter that shares a single memory port between the instruction-fetch port (m0, driven by the IF stage) and the load/store port (m1, driven by the MEM stage). It completes one full transaction at a time: address, data if a write, and response. Requesters are selected round-robin. The block sits between the CPU core's imem/dmem AXI4-Lite masters and a unified memory or interconnect slave.

---
 rtl/axi_lite_mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_axi_lite_mem_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_mem_arbiter.sv
// Two-master / one-slave AXI4-Lite arbiter sharing one memory port between
// instruction fetch (m0) and load/store (m1). One complete transaction at a
// time; requests, addresses and data flow combinationally once granted.
module axi_lite_mem_arbiter #(
  parameter logic RR_ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  // master 0 (instruction fetch)
  input  logic [31:0] m0_axi_awaddr,
  input  logic [2:0]  m0_axi_awprot,
  input  logic        m0_axi_awvalid,
  output logic        m0_axi_awready,
  input  logic [31:0] m0_axi_wdata,
  input  logic [3:0]  m0_axi_wstrb,
  input  logic        m0_axi_wvalid,
  output logic        m0_axi_wready,
  output logic [1:0]  m0_axi_bresp,
  output logic        m0_axi_bvalid,
  input  logic        m0_axi_bready,
  input  logic [31:0] m0_axi_araddr,
  input  logic [2:0]  m0_axi_arprot,
  input  logic        m0_axi_arvalid,
  output logic        m0_axi_arready,
  output logic [31:0] m0_axi_rdata,
  output logic [1:0]  m0_axi_rresp,
  output logic        m0_axi_rvalid,
  input  logic        m0_axi_rready,
  // master 1 (load/store)
  input  logic [31:0] m1_axi_awaddr,
  input  logic [2:0]  m1_axi_awprot,
  input  logic        m1_axi_awvalid,
  output logic        m1_axi_awready,
  input  logic [31:0] m1_axi_wdata,
  input  logic [3:0]  m1_axi_wstrb,
  input  logic        m1_axi_wvalid,
  output logic        m1_axi_wready,
  output logic [1:0]  m1_axi_bresp,
  output logic        m1_axi_bvalid,
  input  logic        m1_axi_bready,
  input  logic [31:0] m1_axi_araddr,
  input  logic [2:0]  m1_axi_arprot,
  input  logic        m1_axi_arvalid,
  output logic        m1_axi_arready,
  output logic [31:0] m1_axi_rdata,
  output logic [1:0]  m1_axi_rresp,
  output logic        m1_axi_rvalid,
  input  logic        m1_axi_rready,
  // shared slave port
  output logic [31:0] s_axi_awaddr,
  output logic [2:0]  s_axi_awprot,
  output logic        s_axi_awvalid,
  input  logic        s_axi_awready,
  output logic [31:0] s_axi_wdata,
  output logic [3:0]  s_axi_wstrb,
  output logic        s_axi_wvalid,
  input  logic        s_axi_wready,
  input  logic [1:0]  s_axi_bresp,
  input  logic        s_axi_bvalid,
  output logic        s_axi_bready,
  output logic [31:0] s_axi_araddr,
  output logic [2:0]  s_axi_arprot,
  output logic        s_axi_arvalid,
  input  logic        s_axi_arready,
  input  logic [31:0] s_axi_rdata,
  input  logic [1:0]  s_axi_rresp,
  input  logic        s_axi_rvalid,
  output logic        s_axi_rready
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} state_t;

  state_t state_q;
  logic   grant_q, is_write_q, aw_done_q, w_done_q, ar_done_q, last_grant_q;

  // Arbitration decision, only consumed while idle
  logic req0, req1, grant_d, is_write_d;
  assign req0       = m0_axi_awvalid | m0_axi_arvalid;
  assign req1       = m1_axi_awvalid | m1_axi_arvalid;
  assign grant_d    = (req0 && req1) ? (RR_ENABLE ? ~last_grant_q : 1'b1) : req1;
  assign is_write_d = grant_d ? m1_axi_awvalid : m0_axi_awvalid;

  // Request channels of the currently granted master
  logic [31:0] sel_awaddr, sel_wdata, sel_araddr;
  logic [2:0]  sel_awprot, sel_arprot;
  logic [3:0]  sel_wstrb;
  logic        sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;
  assign sel_awaddr  = grant_q ? m1_axi_awaddr  : m0_axi_awaddr;
  assign sel_awprot  = grant_q ? m1_axi_awprot  : m0_axi_awprot;
  assign sel_awvalid = grant_q ? m1_axi_awvalid : m0_axi_awvalid;
  assign sel_wdata   = grant_q ? m1_axi_wdata   : m0_axi_wdata;
  assign sel_wstrb   = grant_q ? m1_axi_wstrb   : m0_axi_wstrb;
  assign sel_wvalid  = grant_q ? m1_axi_wvalid  : m0_axi_wvalid;
  assign sel_bready  = grant_q ? m1_axi_bready  : m0_axi_bready;
  assign sel_araddr  = grant_q ? m1_axi_araddr  : m0_axi_araddr;
  assign sel_arprot  = grant_q ? m1_axi_arprot  : m0_axi_arprot;
  assign sel_arvalid = grant_q ? m1_axi_arvalid : m0_axi_arvalid;
  assign sel_rready  = grant_q ? m1_axi_rready  : m0_axi_rready;

  // Everything on the slave side is zero unless a transaction of that kind is open,
  // so an asynchronous reset to IDLE clears all outputs immediately.
  logic rd_act, wr_act;
  assign rd_act = (state_q == READ);
  assign wr_act = (state_q == WRITE) && is_write_q;

  assign s_axi_awaddr  = wr_act ? sel_awaddr : '0;
  assign s_axi_awprot  = wr_act ? sel_awprot : '0;
  assign s_axi_awvalid = wr_act && sel_awvalid && !aw_done_q;
  assign s_axi_wdata   = wr_act ? sel_wdata : '0;
  assign s_axi_wstrb   = wr_act ? sel_wstrb : '0;
  assign s_axi_wvalid  = wr_act && sel_wvalid && !w_done_q;
  assign s_axi_bready  = wr_act && sel_bready;
  assign s_axi_araddr  = rd_act ? sel_araddr : '0;
  assign s_axi_arprot  = rd_act ? sel_arprot : '0;
  assign s_axi_arvalid = rd_act && sel_arvalid && !ar_done_q;
  assign s_axi_rready  = rd_act && sel_rready;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid  && s_axi_wready;
  assign b_hs  = s_axi_bvalid  && s_axi_bready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign r_hs  = s_axi_rvalid  && s_axi_rready;

  // Per-master enables: the non-granted master sees nothing at all
  logic r0_en, r1_en, w0_en, w1_en;
  assign r0_en = rd_act && !grant_q;
  assign r1_en = rd_act &&  grant_q;
  assign w0_en = wr_act && !grant_q;
  assign w1_en = wr_act &&  grant_q;

  assign m0_axi_awready = w0_en && s_axi_awready && !aw_done_q;
  assign m0_axi_wready  = w0_en && s_axi_wready  && !w_done_q;
  assign m0_axi_bresp   = w0_en ? s_axi_bresp : '0;
  assign m0_axi_bvalid  = w0_en && s_axi_bvalid;
  assign m0_axi_arready = r0_en && s_axi_arready && !ar_done_q;
  assign m0_axi_rdata   = r0_en ? s_axi_rdata : '0;
  assign m0_axi_rresp   = r0_en ? s_axi_rresp : '0;
  assign m0_axi_rvalid  = r0_en && s_axi_rvalid;

  assign m1_axi_awready = w1_en && s_axi_awready && !aw_done_q;
  assign m1_axi_wready  = w1_en && s_axi_wready  && !w_done_q;
  assign m1_axi_bresp   = w1_en ? s_axi_bresp : '0;
  assign m1_axi_bvalid  = w1_en && s_axi_bvalid;
  assign m1_axi_arready = r1_en && s_axi_arready && !ar_done_q;
  assign m1_axi_rdata   = r1_en ? s_axi_rdata : '0;
  assign m1_axi_rresp   = r1_en ? s_axi_rresp : '0;
  assign m1_axi_rvalid  = r1_en && s_axi_rvalid;

  // Transaction FSM: grant in IDLE, track channel completion, release on the response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      is_write_q   <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      ar_done_q    <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            state_q    <= is_write_d ? WRITE : READ;
            grant_q    <= grant_d;
            is_write_q <= is_write_d;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            ar_done_q  <= 1'b0;
          end
        end
        READ: begin
          if (ar_hs) ar_done_q <= 1'b1;
          // A response in the same cycle as AR is legal for a combinational slave
          if (r_hs) begin
            state_q      <= IDLE;
            last_grant_q <= grant_q;
          end
        end
        WRITE: begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs)  w_done_q  <= 1'b1;
          // An early B (before W) is a slave error but still ends the transaction
          if (b_hs) begin
            state_q      <= IDLE;
            last_grant_q <= grant_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// Scenario bench for axi_lite_mem_arbiter: a round-robin instance plus a
// fixed-priority instance on the same stimulus, with a response scoreboard.
module tb_axi_lite_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] m0_axi_awaddr = '0, m0_axi_wdata = '0, m0_axi_araddr = '0;
  logic [2:0]  m0_axi_awprot = '0, m0_axi_arprot = '0;
  logic [3:0]  m0_axi_wstrb = '0;
  logic        m0_axi_awvalid = 0, m0_axi_wvalid = 0, m0_axi_bready = 0, m0_axi_arvalid = 0, m0_axi_rready = 0;
  logic [31:0] m1_axi_awaddr = '0, m1_axi_wdata = '0, m1_axi_araddr = '0;
  logic [2:0]  m1_axi_awprot = '0, m1_axi_arprot = '0;
  logic [3:0]  m1_axi_wstrb = '0;
  logic        m1_axi_awvalid = 0, m1_axi_wvalid = 0, m1_axi_bready = 0, m1_axi_arvalid = 0, m1_axi_rready = 0;
  logic        s_axi_awready = 0, s_axi_wready = 0, s_axi_arready = 0, s_axi_bvalid = 0, s_axi_rvalid = 0;
  logic [1:0]  s_axi_bresp = '0, s_axi_rresp = '0;
  logic [31:0] s_axi_rdata = '0;

  // round-robin DUT outputs
  logic        m0_axi_awready, m0_axi_wready, m0_axi_bvalid, m0_axi_arready, m0_axi_rvalid;
  logic [1:0]  m0_axi_bresp, m0_axi_rresp;
  logic [31:0] m0_axi_rdata;
  logic        m1_axi_awready, m1_axi_wready, m1_axi_bvalid, m1_axi_arready, m1_axi_rvalid;
  logic [1:0]  m1_axi_bresp, m1_axi_rresp;
  logic [31:0] m1_axi_rdata;
  logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr;
  logic [2:0]  s_axi_awprot, s_axi_arprot;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_awvalid, s_axi_wvalid, s_axi_bready, s_axi_arvalid, s_axi_rready;

  // fixed-priority DUT outputs
  logic        f_m0_awready, f_m0_wready, f_m0_bvalid, f_m0_arready, f_m0_rvalid;
  logic [1:0]  f_m0_bresp, f_m0_rresp;
  logic [31:0] f_m0_rdata;
  logic        f_m1_awready, f_m1_wready, f_m1_bvalid, f_m1_arready, f_m1_rvalid;
  logic [1:0]  f_m1_bresp, f_m1_rresp;
  logic [31:0] f_m1_rdata;
  logic [31:0] f_s_awaddr, f_s_wdata, f_s_araddr;
  logic [2:0]  f_s_awprot, f_s_arprot;
  logic [3:0]  f_s_wstrb;
  logic        f_s_awvalid, f_s_wvalid, f_s_bready, f_s_arvalid, f_s_rready;

  axi_lite_mem_arbiter #(.RR_ENABLE(1'b1)) dut (
    .clk(clk), .reset(reset),
    .m0_axi_awaddr(m0_axi_awaddr), .m0_axi_awprot(m0_axi_awprot), .m0_axi_awvalid(m0_axi_awvalid), .m0_axi_awready(m0_axi_awready),
    .m0_axi_wdata(m0_axi_wdata), .m0_axi_wstrb(m0_axi_wstrb), .m0_axi_wvalid(m0_axi_wvalid), .m0_axi_wready(m0_axi_wready),
    .m0_axi_bresp(m0_axi_bresp), .m0_axi_bvalid(m0_axi_bvalid), .m0_axi_bready(m0_axi_bready),
    .m0_axi_araddr(m0_axi_araddr), .m0_axi_arprot(m0_axi_arprot), .m0_axi_arvalid(m0_axi_arvalid), .m0_axi_arready(m0_axi_arready),
    .m0_axi_rdata(m0_axi_rdata), .m0_axi_rresp(m0_axi_rresp), .m0_axi_rvalid(m0_axi_rvalid), .m0_axi_rready(m0_axi_rready),
    .m1_axi_awaddr(m1_axi_awaddr), .m1_axi_awprot(m1_axi_awprot), .m1_axi_awvalid(m1_axi_awvalid), .m1_axi_awready(m1_axi_awready),
    .m1_axi_wdata(m1_axi_wdata), .m1_axi_wstrb(m1_axi_wstrb), .m1_axi_wvalid(m1_axi_wvalid), .m1_axi_wready(m1_axi_wready),
    .m1_axi_bresp(m1_axi_bresp), .m1_axi_bvalid(m1_axi_bvalid), .m1_axi_bready(m1_axi_bready),
    .m1_axi_araddr(m1_axi_araddr), .m1_axi_arprot(m1_axi_arprot), .m1_axi_arvalid(m1_axi_arvalid), .m1_axi_arready(m1_axi_arready),
    .m1_axi_rdata(m1_axi_rdata), .m1_axi_rresp(m1_axi_rresp), .m1_axi_rvalid(m1_axi_rvalid), .m1_axi_rready(m1_axi_rready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  axi_lite_mem_arbiter #(.RR_ENABLE(1'b0)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_axi_awaddr(m0_axi_awaddr), .m0_axi_awprot(m0_axi_awprot), .m0_axi_awvalid(m0_axi_awvalid), .m0_axi_awready(f_m0_awready),
    .m0_axi_wdata(m0_axi_wdata), .m0_axi_wstrb(m0_axi_wstrb), .m0_axi_wvalid(m0_axi_wvalid), .m0_axi_wready(f_m0_wready),
    .m0_axi_bresp(f_m0_bresp), .m0_axi_bvalid(f_m0_bvalid), .m0_axi_bready(m0_axi_bready),
    .m0_axi_araddr(m0_axi_araddr), .m0_axi_arprot(m0_axi_arprot), .m0_axi_arvalid(m0_axi_arvalid), .m0_axi_arready(f_m0_arready),
    .m0_axi_rdata(f_m0_rdata), .m0_axi_rresp(f_m0_rresp), .m0_axi_rvalid(f_m0_rvalid), .m0_axi_rready(m0_axi_rready),
    .m1_axi_awaddr(m1_axi_awaddr), .m1_axi_awprot(m1_axi_awprot), .m1_axi_awvalid(m1_axi_awvalid), .m1_axi_awready(f_m1_awready),
    .m1_axi_wdata(m1_axi_wdata), .m1_axi_wstrb(m1_axi_wstrb), .m1_axi_wvalid(m1_axi_wvalid), .m1_axi_wready(f_m1_wready),
    .m1_axi_bresp(f_m1_bresp), .m1_axi_bvalid(f_m1_bvalid), .m1_axi_bready(m1_axi_bready),
    .m1_axi_araddr(m1_axi_araddr), .m1_axi_arprot(m1_axi_arprot), .m1_axi_arvalid(m1_axi_arvalid), .m1_axi_arready(f_m1_arready),
    .m1_axi_rdata(f_m1_rdata), .m1_axi_rresp(f_m1_rresp), .m1_axi_rvalid(f_m1_rvalid), .m1_axi_rready(m1_axi_rready),
    .s_axi_awaddr(f_s_awaddr), .s_axi_awprot(f_s_awprot), .s_axi_awvalid(f_s_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(f_s_wdata), .s_axi_wstrb(f_s_wstrb), .s_axi_wvalid(f_s_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(f_s_bready),
    .s_axi_araddr(f_s_araddr), .s_axi_arprot(f_s_arprot), .s_axi_arvalid(f_s_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(f_s_rready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected responses of the round-robin DUT; kind = {is_write, master}
  typedef struct packed {logic [1:0] kind; logic [31:0] data; logic [1:0] resp;} exp_t;
  exp_t sb[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {m0_axi_awvalid, m0_axi_wvalid, m0_axi_bready, m0_axi_arvalid, m0_axi_rready} = '0;
    {m1_axi_awvalid, m1_axi_wvalid, m1_axi_bready, m1_axi_arvalid, m1_axi_rready} = '0;
    {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid} = '0;
    s_axi_bresp = '0; s_axi_rresp = '0; s_axi_rdata = '0;
  endtask

  // Response monitor: every master-side R/B handshake must match the oldest expectation
  logic        mon_hs [4];
  logic [31:0] mon_d  [4];
  logic [1:0]  mon_r  [4];
  exp_t        mon_e;
  always @(negedge clk) begin
    if (!reset) begin
      mon_hs[0] = m0_axi_rvalid && m0_axi_rready; mon_d[0] = m0_axi_rdata; mon_r[0] = m0_axi_rresp;
      mon_hs[1] = m1_axi_rvalid && m1_axi_rready; mon_d[1] = m1_axi_rdata; mon_r[1] = m1_axi_rresp;
      mon_hs[2] = m0_axi_bvalid && m0_axi_bready; mon_d[2] = '0;           mon_r[2] = m0_axi_bresp;
      mon_hs[3] = m1_axi_bvalid && m1_axi_bready; mon_d[3] = '0;           mon_r[3] = m1_axi_bresp;
      for (int k = 0; k < 4; k++) begin
        if (mon_hs[k]) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: response on channel %0d with nothing expected", k);
          end else begin
            mon_e = sb.pop_front();
            if (mon_e.kind !== k[1:0] || mon_e.resp !== mon_r[k] || (k < 2 && mon_e.data !== mon_d[k])) begin
              n_fail++;
              $display("FAIL sb_resp: got chan %0d data %h resp %b, want chan %0d data %h resp %b",
                       k, mon_d[k], mon_r[k], mon_e.kind, mon_e.data, mon_e.resp);
            end
          end
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    m0_axi_arvalid = 1; m0_axi_araddr = 32'h55; m1_axi_awvalid = 1; m1_axi_awaddr = 32'h66;
    s_axi_arready = 1; s_axi_rvalid = 1; s_axi_bvalid = 1; s_axi_rdata = 32'hFFFF_FFFF;
    reset = 1'b1;
    #1;
    n_checks++; if ({s_axi_arvalid, s_axi_awvalid, s_axi_wvalid, s_axi_rready, s_axi_bready} !== 5'b0) begin n_fail++; $display("FAIL reset_s_ctrl: got %b want 00000", {s_axi_arvalid, s_axi_awvalid, s_axi_wvalid, s_axi_rready, s_axi_bready}); end
    n_checks++; if ({s_axi_araddr, s_axi_awaddr} !== 64'h0) begin n_fail++; $display("FAIL reset_s_addr: got %h want 0", {s_axi_araddr, s_axi_awaddr}); end
    n_checks++; if ({m0_axi_arready, m0_axi_rvalid, m1_axi_awready, m1_axi_bvalid, m0_axi_rdata} !== 36'h0) begin n_fail++; $display("FAIL reset_m_out: got %h want 0", {m0_axi_arready, m0_axi_rvalid, m1_axi_awready, m1_axi_bvalid, m0_axi_rdata}); end
    step();
    clear_inputs();
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    m0_axi_arvalid = 1; m0_axi_araddr = 32'h0000_0100; m0_axi_rready = 1; s_axi_arready = 1;
    #1;
    n_checks++; if (s_axi_arvalid !== 1'b0) begin n_fail++; $display("FAIL rd_idle_cycle0: s_arvalid %b want 0", s_axi_arvalid); end
    step();
    n_checks++; if (s_axi_arvalid !== 1'b1 || s_axi_araddr !== 32'h100) begin n_fail++; $display("FAIL rd_arvalid_cycle1: got %b/%h want 1/00000100", s_axi_arvalid, s_axi_araddr); end
    n_checks++; if (m0_axi_arready !== 1'b1) begin n_fail++; $display("FAIL rd_m0_arready: got %b want 1", m0_axi_arready); end
    n_checks++; if ({m1_axi_arready, m1_axi_rvalid, m1_axi_awready, m1_axi_wready, m1_axi_bvalid} !== 5'b0) begin n_fail++; $display("FAIL rd_m1_quiet: got %b want 00000", {m1_axi_arready, m1_axi_rvalid, m1_axi_awready, m1_axi_wready, m1_axi_bvalid}); end
    step();
    m0_axi_arvalid = 0; s_axi_rvalid = 1; s_axi_rdata = 32'hDEAD_BEEF; s_axi_rresp = 2'b00;
    sb.push_back('{kind: 2'd0, data: 32'hDEAD_BEEF, resp: 2'b00});
    #1;
    n_checks++; if (s_axi_arvalid !== 1'b0 || m0_axi_rvalid !== 1'b1) begin n_fail++; $display("FAIL rd_r_phase: arvalid/rvalid %b%b want 01", s_axi_arvalid, m0_axi_rvalid); end
    step();
    s_axi_rvalid = 0;
    #1;
    n_checks++; if (m0_axi_rvalid !== 1'b0 || s_axi_rready !== 1'b0) begin n_fail++; $display("FAIL rd_back_idle: rvalid/rready %b%b want 00", m0_axi_rvalid, s_axi_rready); end
    clear_inputs();
  endtask

  task automatic test_tie_rr_and_fp();
    do_reset();
    m0_axi_arvalid = 1; m0_axi_araddr = 32'h10; m0_axi_rready = 1;
    m1_axi_arvalid = 1; m1_axi_araddr = 32'h20; m1_axi_rready = 1;
    s_axi_arready = 1; s_axi_rvalid = 1; s_axi_rdata = 32'hA5A5_0000;
    step();
    sb.push_back('{kind: 2'd0, data: 32'hA5A5_0000, resp: 2'b00});
    #1;
    n_checks++; if (s_axi_araddr !== 32'h10 || m0_axi_arready !== 1'b1 || m1_axi_arready !== 1'b0) begin n_fail++; $display("FAIL tie_rr_first: addr %h ardy %b%b want 00000010 m0", s_axi_araddr, m0_axi_arready, m1_axi_arready); end
    n_checks++; if (f_s_araddr !== 32'h20 || f_m1_arready !== 1'b1 || f_m0_arready !== 1'b0) begin n_fail++; $display("FAIL tie_fp_first: addr %h ardy %b%b want 00000020 m1", f_s_araddr, f_m0_arready, f_m1_arready); end
    step();
    n_checks++; if (s_axi_arvalid !== 1'b0 || f_s_arvalid !== 1'b0) begin n_fail++; $display("FAIL tie_idle_gap: arvalid rr/fp %b%b want 00", s_axi_arvalid, f_s_arvalid); end
    step();
    sb.push_back('{kind: 2'd1, data: 32'hA5A5_0000, resp: 2'b00});
    #1;
    n_checks++; if (s_axi_araddr !== 32'h20 || m1_axi_arready !== 1'b1 || m0_axi_arready !== 1'b0) begin n_fail++; $display("FAIL tie_rr_second: addr %h ardy %b%b want 00000020 m1", s_axi_araddr, m0_axi_arready, m1_axi_arready); end
    n_checks++; if (f_s_araddr !== 32'h20 || f_m1_arready !== 1'b1) begin n_fail++; $display("FAIL tie_fp_second: addr %h ardy %b want 00000020 1", f_s_araddr, f_m1_arready); end
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_write_delayed_w();
    m1_axi_awvalid = 1; m1_axi_awaddr = 32'h0000_2000; m1_axi_wvalid = 1; m1_axi_wdata = 32'h1234_5678;
    m1_axi_wstrb = 4'b0011; m1_axi_bready = 1; s_axi_awready = 1; s_axi_wready = 0;
    step();
    #1;
    n_checks++; if (s_axi_awvalid !== 1'b1 || s_axi_awaddr !== 32'h2000 || m1_axi_awready !== 1'b1) begin n_fail++; $display("FAIL wr_aw: %b %h %b want 1 00002000 1", s_axi_awvalid, s_axi_awaddr, m1_axi_awready); end
    n_checks++; if (s_axi_wvalid !== 1'b1 || m1_axi_wready !== 1'b0 || m0_axi_awready !== 1'b0) begin n_fail++; $display("FAIL wr_w_wait: wvalid %b wready %b m0_awready %b want 1 0 0", s_axi_wvalid, m1_axi_wready, m0_axi_awready); end
    for (int c = 0; c < 2; c++) begin
      step();
      m1_axi_awvalid = 0;
      #1;
      n_checks++; if (s_axi_awvalid !== 1'b0 || s_axi_wvalid !== 1'b1) begin n_fail++; $display("FAIL wr_hold_%0d: awvalid/wvalid %b%b want 01", c, s_axi_awvalid, s_axi_wvalid); end
    end
    step();
    s_axi_wready = 1;
    #1;
    n_checks++; if (m1_axi_wready !== 1'b1 || s_axi_wdata !== 32'h1234_5678 || s_axi_wstrb !== 4'b0011) begin n_fail++; $display("FAIL wr_w_hs: wready %b data %h strb %b want 1 12345678 0011", m1_axi_wready, s_axi_wdata, s_axi_wstrb); end
    step();
    m1_axi_wvalid = 0; s_axi_wready = 0; s_axi_bvalid = 1; s_axi_bresp = 2'b00;
    sb.push_back('{kind: 2'd3, data: 32'h0, resp: 2'b00});
    #1;
    n_checks++; if (s_axi_wvalid !== 1'b0 || m1_axi_bvalid !== 1'b1 || s_axi_bready !== 1'b1) begin n_fail++; $display("FAIL wr_b: wvalid %b bvalid %b bready %b want 0 1 1", s_axi_wvalid, m1_axi_bvalid, s_axi_bready); end
    step();
    s_axi_bvalid = 0;
    #1;
    n_checks++; if (m1_axi_bvalid !== 1'b0 || s_axi_bready !== 1'b0) begin n_fail++; $display("FAIL wr_back_idle: bvalid/bready %b%b want 00", m1_axi_bvalid, s_axi_bready); end
    clear_inputs();
  endtask

  task automatic test_wr_then_rd();
    m1_axi_awvalid = 1; m1_axi_wvalid = 1; m1_axi_arvalid = 1; m1_axi_awaddr = 32'h3000; m1_axi_araddr = 32'h3000;
    m1_axi_bready = 1; m1_axi_rready = 1; m0_axi_rready = 1; m0_axi_araddr = 32'h4000;
    s_axi_awready = 1; s_axi_wready = 1; s_axi_arready = 1; s_axi_bvalid = 1; s_axi_rvalid = 1; s_axi_rdata = 32'h0BAD_F00D;
    step();
    sb.push_back('{kind: 2'd3, data: 32'h0, resp: 2'b00});
    #1;
    n_checks++; if (s_axi_awvalid !== 1'b1 || s_axi_arvalid !== 1'b0 || m1_axi_bvalid !== 1'b1) begin n_fail++; $display("FAIL wr_first: aw %b ar %b b %b want 1 0 1", s_axi_awvalid, s_axi_arvalid, m1_axi_bvalid); end
    step();
    m1_axi_awvalid = 0; m1_axi_wvalid = 0;
    step();
    sb.push_back('{kind: 2'd1, data: 32'h0BAD_F00D, resp: 2'b00});
    #1;
    n_checks++; if (s_axi_arvalid !== 1'b1 || s_axi_araddr !== 32'h3000 || m1_axi_arready !== 1'b1) begin n_fail++; $display("FAIL rd_follows: %b %h %b want 1 00003000 1", s_axi_arvalid, s_axi_araddr, m1_axi_arready); end
    step();
    m1_axi_arvalid = 0;
    #1;
    m1_axi_awvalid = 1; m1_axi_wvalid = 1; m1_axi_arvalid = 1;
    step();
    sb.push_back('{kind: 2'd3, data: 32'h0, resp: 2'b00});
    m0_axi_arvalid = 1;
    #1;
    n_checks++; if (s_axi_awvalid !== 1'b1 || m0_axi_arready !== 1'b0) begin n_fail++; $display("FAIL wr2_first: awvalid %b m0_arready %b want 1 0", s_axi_awvalid, m0_axi_arready); end
    step();
    m1_axi_awvalid = 0; m1_axi_wvalid = 0;
    step();
    sb.push_back('{kind: 2'd0, data: 32'h0BAD_F00D, resp: 2'b00});
    #1;
    n_checks++; if (s_axi_araddr !== 32'h4000 || m0_axi_arready !== 1'b1 || m1_axi_arready !== 1'b0) begin n_fail++; $display("FAIL rr_m0_waiting: addr %h ardy %b%b want 00004000 m0", s_axi_araddr, m0_axi_arready, m1_axi_arready); end
    step();
    m0_axi_arvalid = 0;
    step();
    sb.push_back('{kind: 2'd1, data: 32'h0BAD_F00D, resp: 2'b00});
    #1;
    n_checks++; if (s_axi_araddr !== 32'h3000 || m1_axi_arready !== 1'b1) begin n_fail++; $display("FAIL rd2_m1: addr %h ardy %b want 00003000 1", s_axi_araddr, m1_axi_arready); end
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_redirect();
    m0_axi_arvalid = 1; m0_axi_araddr = 32'h100; m0_axi_rready = 1; s_axi_arready = 0;
    step();
    #1;
    n_checks++; if (s_axi_arvalid !== 1'b1 || s_axi_araddr !== 32'h100 || m0_axi_arready !== 1'b0) begin n_fail++; $display("FAIL redir_before: %b %h %b want 1 00000100 0", s_axi_arvalid, s_axi_araddr, m0_axi_arready); end
    m0_axi_araddr = 32'h200;
    #1;
    n_checks++; if (s_axi_araddr !== 32'h200) begin n_fail++; $display("FAIL redir_same_cycle: addr %h want 00000200", s_axi_araddr); end
    step();
    s_axi_arready = 1;
    #1;
    n_checks++; if (s_axi_araddr !== 32'h200 || m0_axi_arready !== 1'b1) begin n_fail++; $display("FAIL redir_hs: addr %h ardy %b want 00000200 1", s_axi_araddr, m0_axi_arready); end
    step();
    m0_axi_arvalid = 0; s_axi_arready = 0; s_axi_rvalid = 1; s_axi_rresp = 2'b10; s_axi_rdata = 32'hCAFE_0200;
    sb.push_back('{kind: 2'd0, data: 32'hCAFE_0200, resp: 2'b10});
    #1;
    n_checks++; if (m0_axi_rresp !== 2'b10 || s_axi_arvalid !== 1'b0) begin n_fail++; $display("FAIL redir_rresp: rresp %b arvalid %b want 10 0", m0_axi_rresp, s_axi_arvalid); end
    step();
    clear_inputs();
    #1;
    n_checks++; if (m0_axi_rvalid !== 1'b0) begin n_fail++; $display("FAIL redir_done: rvalid %b want 0", m0_axi_rvalid); end
  endtask

  task automatic test_reset_mid_read();
    m0_axi_arvalid = 1; m0_axi_araddr = 32'h500; m0_axi_rready = 0; s_axi_arready = 1;
    step();
    step();
    m0_axi_arvalid = 0; s_axi_arready = 0; s_axi_rvalid = 1; s_axi_rdata = 32'h1111_2222;
    m1_axi_arvalid = 1; m1_axi_araddr = 32'h600;
    #1;
    n_checks++; if (m0_axi_rvalid !== 1'b1 || m0_axi_rdata !== 32'h1111_2222) begin n_fail++; $display("FAIL rst_pending: rvalid %b data %h want 1 11112222", m0_axi_rvalid, m0_axi_rdata); end
    #1;
    reset = 1'b1;
    #1;
    n_checks++; if ({m0_axi_rvalid, s_axi_rready, s_axi_arvalid, m1_axi_arready} !== 4'b0 || {m0_axi_rdata, s_axi_araddr} !== 64'h0) begin n_fail++; $display("FAIL rst_async_outputs: ctl %b data %h want 0000 0", {m0_axi_rvalid, s_axi_rready, s_axi_arvalid, m1_axi_arready}, {m0_axi_rdata, s_axi_araddr}); end
    step();
    reset = 1'b0; s_axi_rvalid = 0; s_axi_arready = 1; m0_axi_arvalid = 1; m0_axi_araddr = 32'h700;
    step();
    #1;
    n_checks++; if (s_axi_araddr !== 32'h700 || m0_axi_arready !== 1'b1 || m1_axi_arready !== 1'b0) begin n_fail++; $display("FAIL rst_last_grant: addr %h ardy %b%b want 00000700 m0", s_axi_araddr, m0_axi_arready, m1_axi_arready); end
    clear_inputs();
    do_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    step();
    test_single_read();
    test_tie_rr_and_fp();
    test_write_delayed_w();
    test_wr_then_rd();
    test_redirect();
    test_reset_mid_read();
    step();
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drained: %0d responses never seen, want 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
